// File: rtl/ifu_pf.sv
// ifu_pf - instruction fetch unit with redirect support and a prefetch FIFO.
//
// Keeps a PC and issues one sequential fetch per cycle to a fixed-latency
// (1-cycle) instruction memory. Returned words are buffered with their PCs in
// a DEPTH-entry FIFO that drains to decode through a valid/ready handshake.
//
// Parameters:
//   RESET_PC  first fetch address after reset (word aligned)
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   imem_req/addr   fetch request and word-aligned address
//   imem_rdata      instruction word, valid one cycle after an issued request
//   inst_valid/ready/out/pc  decode-side handshake, head instruction and its PC
//   redirect_valid/pc        flush and restart fetch at redirect_pc
//   misalign_err    sticky flag for a redirect with redirect_pc[1:0] != 0
//
// Optional feature: define IFU_ALIGN_CHK_EN to enable misalign_err. With the
// macro undefined misalign_err is tied to 0. The low two address bits of a
// redirect are dropped in both builds.
module ifu_pf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_C = DEPTH[AW+1:0];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic [31:0]   pc;
  logic [31:0]   tag_pc;
  logic          inflight;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  ent_t          mem [DEPTH];

  logic [AW+1:0] credit;
  logic          push, pop;
  ent_t          head;

  // Credit check counts the outstanding response but not a same-cycle pop,
  // so a full FIFO always resumes fetching one cycle after decode drains it.
  assign credit    = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
  assign imem_req  = !rst && !redirect_valid && (credit < DEPTH_C);
  assign imem_addr = pc;

  // A response arriving in a redirect (or reset) cycle belongs to the old
  // stream and is dropped.
  assign push = !rst && !redirect_valid && inflight;

  assign head       = mem[rd_ptr];
  assign inst_valid = !rst && (count != '0);
  assign inst_out   = head.inst;
  assign inst_pc    = head.pc;
  assign pop        = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      tag_pc   <= RESET_PC;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      // Flush: entries between rd_ptr and wr_ptr become dead; wr_ptr is kept.
      pc       <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= wr_ptr;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc     <= pc + 32'd4;
        tag_pc <= pc;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: tag_pc, inst: imem_rdata};
  end

`ifdef IFU_ALIGN_CHK_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (rst)
      misalign_q <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
      misalign_q <= 1'b1;
  end
  assign misalign_err = misalign_q;
`else
  logic [1:0] unused_redir_lsb;
  assign unused_redir_lsb = redirect_pc[1:0];
  assign misalign_err     = 1'b0;
`endif

endmodule
